// File: rtl/regfile_wr_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler:
// register-file geometry, PC address and FSM state encodings.
package regfile_wr_sched_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 4;
  localparam int NREG   = 15;

  localparam logic [3:0] REG_PC = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR1  = 2'd1;
  localparam logic [1:0] ST_WR2  = 2'd2;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Bus bundle between the writeback requesters / regfile and the write scheduler.
interface regfile_wr_sched_if
  import regfile_wr_sched_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  // Handshake: a request transfers at a rising edge where rN_valid & rN_ready are both 1.
  // rN_valid must not depend on rN_ready; request fields are only sampled at that edge.
  logic          r0_valid;
  logic          r0_ready;
  logic          r0_long;
  logic [AW-1:0] r0_a3;
  logic [AW-1:0] r0_a4;
  logic [DW-1:0] r0_wd3;
  logic [DW-1:0] r0_wd4;

  logic          r1_valid;
  logic          r1_ready;
  logic          r1_long;
  logic [AW-1:0] r1_a3;
  logic [AW-1:0] r1_a4;
  logic [DW-1:0] r1_wd3;
  logic [DW-1:0] r1_wd4;

  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          hazard1;
  logic          hazard2;

  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic          idle;

  logic [1:0]    dbg_state;
  logic          dbg_last_grant;

  modport master (
    output r0_valid, r0_long, r0_a3, r0_a4, r0_wd3, r0_wd4,
    output r1_valid, r1_long, r1_a3, r1_a4, r1_wd3, r1_wd4,
    output ra1, ra2,
    input  r0_ready, r1_ready, hazard1, hazard2,
    input  rf_we, rf_wa, rf_wd, pc_we, pc_wd, idle,
    input  dbg_state, dbg_last_grant
  );

  modport slave (
    input  r0_valid, r0_long, r0_a3, r0_a4, r0_wd3, r0_wd4,
    input  r1_valid, r1_long, r1_a3, r1_a4, r1_wd3, r1_wd4,
    input  ra1, ra2,
    output r0_ready, r1_ready, hazard1, hazard2,
    output rf_we, rf_wa, rf_wd, pc_we, pc_wd, idle,
    output dbg_state, dbg_last_grant
  );

endinterface

// File: rtl/regfile_wr_sched_rr_arb2.sv
// Two-way arbiter: round-robin (RR != 0) or fixed priority to requester 0.
module rr_arb2 #(
  parameter int RR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie, round-robin favours whoever did not win the last accepted request.
      2'b11:   grant = ((RR != 0) && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: arbitrates two writeback requesters onto the single regfile
// write port, splits long multiplies into two slots, redirects r15 writes to the PC.
module regfile_wr_sched
  import regfile_wr_sched_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int RR = 1
) (
  input  logic               clk,
  input  logic               reset,
  regfile_wr_sched_if.slave  bus
);

  localparam logic [AW-1:0] PC_ADDR = AW'(REG_PC);

  logic [1:0]    state;
  logic [1:0]    state_nxt;

  logic          h_long;
  logic [AW-1:0] h_a3;
  logic [AW-1:0] h_a4;
  logic [DW-1:0] h_wd3;
  logic [DW-1:0] h_wd4;

  logic [1:0]    req;
  logic [1:0]    grant;
  logic          last_grant;
  logic          can_accept;
  logic          accept;

  logic          slot_act;
  logic          slot_pc;
  logic [AW-1:0] slot_a;
  logic [DW-1:0] slot_d;

  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] pcwd_q;

  assign req = {bus.r1_valid, bus.r0_valid};

  rr_arb2 #(.RR(RR)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .accept     (accept),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // The entry frees up during its final slot, so a new request can overlap it.
  assign can_accept = ~reset & ((state == ST_IDLE) |
                                ((state == ST_WR1) & ~h_long) |
                                (state == ST_WR2));
  assign accept     = can_accept & (|req);

  assign bus.r0_ready = can_accept & grant[0];
  assign bus.r1_ready = can_accept & grant[1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_WR1;
      end
      ST_WR1: begin
        if (h_long)      state_nxt = ST_WR2;
        else if (accept) state_nxt = ST_WR1;
        else             state_nxt = ST_IDLE;
      end
      ST_WR2: begin
        state_nxt = accept ? ST_WR1 : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_long <= 1'b0;
      h_a3   <= '0;
      h_a4   <= '0;
      h_wd3  <= '0;
      h_wd4  <= '0;
    end else if (accept) begin
      if (grant[1]) begin
        h_long <= bus.r1_long;
        h_a3   <= bus.r1_a3;
        h_a4   <= bus.r1_a4;
        h_wd3  <= bus.r1_wd3;
        h_wd4  <= bus.r1_wd4;
      end else begin
        h_long <= bus.r0_long;
        h_a3   <= bus.r0_a3;
        h_a4   <= bus.r0_a4;
        h_wd3  <= bus.r0_wd3;
        h_wd4  <= bus.r0_wd4;
      end
    end
  end

  assign slot_act = (state != ST_IDLE);
  assign slot_a   = (state == ST_WR2) ? h_a4  : h_a3;
  assign slot_d   = (state == ST_WR2) ? h_wd4 : h_wd3;
  assign slot_pc  = slot_act & (slot_a == PC_ADDR);

  // Address/data buses keep their last regfile value when idle or redirected to the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wa_q   <= '0;
      wd_q   <= '0;
      pcwd_q <= '0;
    end else begin
      if (slot_act & ~slot_pc) begin
        wa_q <= slot_a;
        wd_q <= slot_d;
      end
      if (slot_pc) begin
        pcwd_q <= slot_d;
      end
    end
  end

  assign bus.rf_we = slot_act & ~slot_pc;
  assign bus.rf_wa = bus.rf_we ? slot_a : wa_q;
  assign bus.rf_wd = bus.rf_we ? slot_d : wd_q;
  assign bus.pc_we = slot_pc;
  assign bus.pc_wd = slot_pc ? slot_d : pcwd_q;

  // The second half of a long is already committed during WR1, so it counts as in flight.
  assign bus.hazard1 = (bus.ra1 != PC_ADDR) &
                       ((slot_act & (slot_a == bus.ra1)) |
                        ((state == ST_WR1) & h_long & (h_a4 == bus.ra1)));
  assign bus.hazard2 = (bus.ra2 != PC_ADDR) &
                       ((slot_act & (slot_a == bus.ra2)) |
                        ((state == ST_WR1) & h_long & (h_a4 == bus.ra2)));

  assign bus.idle           = (state == ST_IDLE);
  assign bus.dbg_state      = state;
  assign bus.dbg_last_grant = last_grant;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: round-robin instance (a) plus fixed-priority instance (b).
module tb_regfile_wr_sched;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  logic [35:0] exp_q[$];
  logic [35:0] exp_e;

  regfile_wr_sched_if #(.DW(32), .AW(4)) a_if ();
  regfile_wr_sched_if #(.DW(32), .AW(4)) b_if ();

  regfile_wr_sched #(.DW(32), .AW(4), .RR(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  regfile_wr_sched #(.DW(32), .AW(4), .RR(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_valids();
    a_if.r0_valid = 1'b0;
    a_if.r1_valid = 1'b0;
    b_if.r0_valid = 1'b0;
    b_if.r1_valid = 1'b0;
  endtask

  task automatic clr_all();
    clr_valids();
    a_if.r0_long = 1'b0; a_if.r0_a3 = '0; a_if.r0_a4 = '0; a_if.r0_wd3 = '0; a_if.r0_wd4 = '0;
    a_if.r1_long = 1'b0; a_if.r1_a3 = '0; a_if.r1_a4 = '0; a_if.r1_wd3 = '0; a_if.r1_wd4 = '0;
    b_if.r0_long = 1'b0; b_if.r0_a3 = '0; b_if.r0_a4 = '0; b_if.r0_wd3 = '0; b_if.r0_wd4 = '0;
    b_if.r1_long = 1'b0; b_if.r1_a3 = '0; b_if.r1_a4 = '0; b_if.r1_wd3 = '0; b_if.r1_wd4 = '0;
    a_if.ra1 = 4'd0; a_if.ra2 = 4'd0;
    b_if.ra1 = 4'd0; b_if.ra2 = 4'd0;
  endtask

  // Driver for instance a
  task automatic drive_a(input int who, input logic lng, input logic [3:0] a3, input logic [3:0] a4,
                         input logic [31:0] d3, input logic [31:0] d4);
    if (who == 0) begin
      a_if.r0_valid = 1'b1; a_if.r0_long = lng; a_if.r0_a3 = a3; a_if.r0_a4 = a4;
      a_if.r0_wd3 = d3; a_if.r0_wd4 = d4;
    end else begin
      a_if.r1_valid = 1'b1; a_if.r1_long = lng; a_if.r1_a3 = a3; a_if.r1_a4 = a4;
      a_if.r1_wd3 = d3; a_if.r1_wd4 = d4;
    end
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard: every regfile write of instance a must match the expected queue in order.
  always @(negedge clk) begin
    if (!reset && a_if.rf_we) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {28'd0, a_if.rf_wa}, 32'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", {28'd0, a_if.rf_wa}, {28'd0, exp_e[35:32]});
        check("wr_data", a_if.rf_wd, exp_e[31:0]);
      end
    end
  end

  initial begin
    clr_all();
    reset = 1'b1;
    a_if.r0_valid = 1'b1;
    b_if.r0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_r0_ready", a_if.r0_ready, 0);
    check("rst_b_r0_ready", b_if.r0_ready, 0);
    check("rst_idle", a_if.idle, 1);
    check("rst_rf_we", a_if.rf_we, 0);
    check("rst_rf_wa", a_if.rf_wa, 0);
    check("rst_rf_wd", a_if.rf_wd, 0);
    check("rst_pc_we", a_if.pc_we, 0);
    check("rst_pc_wd", a_if.pc_wd, 0);
    check("rst_hazard1", a_if.hazard1, 0);
    check("rst_hazard2", a_if.hazard2, 0);
    clr_valids();
    reset = 1'b0;
    step();

    // Single write from r0
    drive_a(0, 1'b0, 4'd5, 4'd0, 32'hDEAD_BEEF, 32'h0);
    #1;
    check("single_ready", a_if.r0_ready, 1);
    expect_wr(4'd5, 32'hDEAD_BEEF);
    step();
    clr_valids();
    #1;
    check("single_rf_we", a_if.rf_we, 1);
    check("single_rf_wa", a_if.rf_wa, 5);
    check("single_rf_wd", a_if.rf_wd, 32'hDEAD_BEEF);
    check("single_busy", a_if.idle, 0);
    step();
    check("single_idle", a_if.idle, 1);
    check("single_we_off", a_if.rf_we, 0);
    check("single_wa_hold", a_if.rf_wa, 5);

    // Long from r1; both requesters blocked during WR1, field changes ignored
    drive_a(1, 1'b1, 4'd1, 4'd2, 32'hAAAA, 32'hBBBB);
    #1;
    check("long_ready", a_if.r1_ready, 1);
    expect_wr(4'd1, 32'hAAAA);
    expect_wr(4'd2, 32'hBBBB);
    step();
    drive_a(0, 1'b0, 4'd9, 4'd0, 32'h9999, 32'h0);
    a_if.r1_wd4 = 32'h5555;
    #1;
    check("long_wr1_r0_ready", a_if.r0_ready, 0);
    check("long_wr1_r1_ready", a_if.r1_ready, 0);
    check("long_wr1_wa", a_if.rf_wa, 1);
    check("long_wr1_wd", a_if.rf_wd, 32'hAAAA);
    clr_valids();
    step();
    check("long_wr2_we", a_if.rf_we, 1);
    check("long_wr2_wa", a_if.rf_wa, 2);
    check("long_wr2_wd", a_if.rf_wd, 32'hBBBB);
    step();
    check("long_idle", a_if.idle, 1);

    // Arbitration with both requesters valid every cycle: a is round-robin, b is fixed
    drive_a(0, 1'b0, 4'd6, 4'd0, 32'h60, 32'h0);
    drive_a(1, 1'b0, 4'd7, 4'd0, 32'h70, 32'h0);
    b_if.r0_valid = 1'b1; b_if.r0_a3 = 4'd6; b_if.r0_wd3 = 32'h60;
    b_if.r1_valid = 1'b1; b_if.r1_a3 = 4'd7; b_if.r1_wd3 = 32'h70;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("arb_rr_r0_ready", a_if.r0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("arb_rr_r1_ready", a_if.r1_ready, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("arb_fp_r0_ready", b_if.r0_ready, 1);
      check("arb_fp_r1_ready", b_if.r1_ready, 0);
      if (i % 2 == 0) expect_wr(4'd6, 32'h60);
      else            expect_wr(4'd7, 32'h70);
      step();
    end
    clr_valids();
    #1;
    check("arb_rr_last_wa", a_if.rf_wa, 7);
    check("arb_fp_last_wa", b_if.rf_wa, 6);
    step();
    check("arb_idle", a_if.idle, 1);

    // PC redirect
    drive_a(0, 1'b0, 4'hF, 4'd0, 32'h100, 32'h0);
    #1;
    check("pc_ready", a_if.r0_ready, 1);
    step();
    clr_valids();
    a_if.ra1 = 4'hF;
    #1;
    check("pc_we", a_if.pc_we, 1);
    check("pc_wd", a_if.pc_wd, 32'h100);
    check("pc_rf_we", a_if.rf_we, 0);
    check("pc_rf_wa_hold", a_if.rf_wa, 7);
    check("pc_rf_wd_hold", a_if.rf_wd, 32'h70);
    check("pc_hazard1", a_if.hazard1, 0);
    step();
    check("pc_we_off", a_if.pc_we, 0);

    // Hazards across a long a3=4, a4=7
    a_if.ra1 = 4'd7;
    a_if.ra2 = 4'd4;
    drive_a(0, 1'b1, 4'd4, 4'd7, 32'h44, 32'h77);
    #1;
    check("hz_pre_h1", a_if.hazard1, 0);
    check("hz_pre_h2", a_if.hazard2, 0);
    expect_wr(4'd4, 32'h44);
    expect_wr(4'd7, 32'h77);
    step();
    clr_valids();
    #1;
    check("hz_wr1_h1", a_if.hazard1, 1);
    check("hz_wr1_h2", a_if.hazard2, 1);
    step();
    check("hz_wr2_h1", a_if.hazard1, 1);
    check("hz_wr2_h2", a_if.hazard2, 0);
    step();
    check("hz_idle_h1", a_if.hazard1, 0);
    check("hz_idle_h2", a_if.hazard2, 0);
    a_if.ra1 = 4'd0;
    a_if.ra2 = 4'd0;

    // Long with a3 == a4: both slots issue, second value last
    drive_a(1, 1'b1, 4'd8, 4'd8, 32'h1, 32'h2);
    #1;
    check("same_ready", a_if.r1_ready, 1);
    expect_wr(4'd8, 32'h1);
    expect_wr(4'd8, 32'h2);
    step();
    clr_valids();
    #1;
    check("same_wr1_wd", a_if.rf_wd, 32'h1);
    step();
    check("same_wr2_wd", a_if.rf_wd, 32'h2);
    step();

    // Reset during WR2 of a long: r3 must never be written
    drive_a(0, 1'b1, 4'd2, 4'd3, 32'h11, 32'h22);
    #1;
    check("rml_ready", a_if.r0_ready, 1);
    expect_wr(4'd2, 32'h11);
    step();
    clr_valids();
    #1;
    check("rml_wr1_wa", a_if.rf_wa, 2);
    step();
    check("rml_wr2_wa", a_if.rf_wa, 3);
    reset = 1'b1;
    #1;
    check("rml_rf_we", a_if.rf_we, 0);
    check("rml_idle", a_if.idle, 1);
    check("rml_rf_wa", a_if.rf_wa, 0);
    check("rml_rf_wd", a_if.rf_wd, 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("rml_post_idle", a_if.idle, 1);
    check("rml_post_we", a_if.rf_we, 0);

    step();
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
